// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types and defaults for the CNN pooling datapath
package cnn_pkg;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } feeder_state_t;

  // Pixel width shared with the 2x2 reduction stage downstream.
  localparam int DEFAULT_DATA_WIDTH = 16;

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - one-row pixel store, synchronous write, combinational read
module line_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 24,
  parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pool_column_feeder.sv
// rtl/pool_column_feeder.sv - buffers even rows and emits top/bottom pixel columns on odd rows
module pool_column_feeder
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int IMG_WIDTH  = 24,
  parameter int IMG_HEIGHT = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [1:0][DATA_WIDTH-1:0] out_col,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_window_last,
  output logic                       out_frame_last
);

  localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  feeder_state_t         state;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [DATA_WIDTH-1:0] above;
  logic                  x_last;
  logic                  y_last;
  logic                  in_fire;
  logic                  col_load;

  assign x_last   = (x == X_LAST);
  assign y_last   = (y == Y_LAST);
  // FILL never stalls; the output register is only written from STREAM.
  assign in_ready = (state == FILL) || !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign col_load = in_fire && (state == STREAM);

  line_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (IMG_WIDTH),
    .AW        (XW)
  ) u_line_buffer (
    .clk  (clk),
    .we   (in_fire && (state == FILL)),
    .waddr(x),
    .wdata(in_data),
    .raddr(x),
    .rdata(above)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= FILL;
      x               <= '0;
      y               <= '0;
      out_valid       <= 1'b0;
      out_col         <= '0;
      out_window_last <= 1'b0;
      out_frame_last  <= 1'b0;
    end else begin
      if (in_fire) begin
        if (x_last) begin
          x     <= '0;
          y     <= y_last ? '0 : y + 1'b1;
          state <= (state == FILL) ? STREAM : FILL;
        end else begin
          x <= x + 1'b1;
        end
      end
      // A load in the same cycle as a downstream handshake replaces the old column.
      if (col_load) begin
        out_col[0]      <= above;
        out_col[1]      <= in_data;
        out_window_last <= x[0];
        out_frame_last  <= x_last && y_last;
        out_valid       <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pool_column_feeder.sv
// tb/tb_pool_column_feeder.sv - scoreboard bench for pool_column_feeder
module tb_pool_column_feeder;

  localparam int DW = 16;
  localparam int W  = 4;
  localparam int H  = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [DW-1:0]       in_data;
  logic                in_valid;
  logic                in_ready;
  logic [1:0][DW-1:0]  out_col;
  logic                out_valid;
  logic                out_ready;
  logic                out_window_last;
  logic                out_frame_last;

  pool_column_feeder #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_col        (out_col),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_window_last(out_window_last),
    .out_frame_last (out_frame_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] top;
    logic [DW-1:0] bot;
    logic          wl;
    logic          fl;
    int            acc_cyc;
  } exp_t;

  exp_t          q[$];
  exp_t          e;
  logic [DW-1:0] img [H][W];
  int            p = 0;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_pass = 0;
  int            fl_seen = 0;
  bit            fresh = 1'b1;
  bit            rand_ready = 1'b0;
  int            waits;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Reference: whole-frame image; an odd-row pixel pairs with the same x one row up.
  task automatic model_accept(input logic [DW-1:0] d);
    int mx, my;
    exp_t ne;
    mx = p % W;
    my = (p / W) % H;
    img[my][mx] = d;
    if (my % 2 == 1) begin
      ne.top     = img[my-1][mx];
      ne.bot     = d;
      ne.wl      = (mx % 2 == 1);
      ne.fl      = (mx == W - 1) && (my == H - 1);
      ne.acc_cyc = cyc + 1;
      q.push_back(ne);
    end
    p = (p + 1) % (W * H);
  endtask

  task automatic send(input logic [DW-1:0] d, output int nwait);
    nwait    = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(d);
        break;
      end
      nwait++;
      if (nwait > 200) begin
        chk("send_accept", in_ready, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    in_valid   = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      fresh = 1'b1;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_column", {out_col[0], out_col[1]}, 0);
        fresh = !out_ready;
      end else begin
        e = q[0];
        if (fresh) chk("latency", cyc, e.acc_cyc);
        chk("column", {out_col[0], out_col[1], out_window_last, out_frame_last},
            {e.top, e.bot, e.wl, e.fl});
        if (out_ready) begin
          void'(q.pop_front());
          if (out_frame_last) fl_seen++;
          fresh = 1'b1;
        end else begin
          fresh = 1'b0;
        end
      end
    end else begin
      fresh = 1'b1;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("reset_out_col", {out_col, out_window_last, out_frame_last}, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_in_ready", in_ready, 1);
    end
    @(posedge clk);
    #1;

    // Frame 1..16 with a stall on (2,6) and a stall spanning the FILL of row 2.
    fl_seen = 0;
    for (int v = 1; v <= 6; v++) send(DW'(v), waits);
    out_ready = 1'b0;
    in_data   = 16'd7;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_hold", {out_valid, out_col[0], out_col[1]}, {1'b1, 16'd2, 16'd6});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(16'd7, waits);
    send(16'd8, waits);
    out_ready = 1'b0;
    for (int v = 9; v <= 12; v++) begin
      send(DW'(v), waits);
      chk("fill_no_stall", waits, 0);
    end
    @(negedge clk);
    chk("row_end_hold", {out_valid, out_col[0], out_col[1]}, {1'b1, 16'd4, 16'd8});
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int v = 13; v <= 16; v++) send(DW'(v), waits);
    drain();
    chk("frame_last_count_1", fl_seen, 1);

    // Back-to-back frames.
    fl_seen = 0;
    for (int v = 1; v <= 32; v++) send(DW'(v), waits);
    drain();
    chk("frame_last_count_2", fl_seen, 2);

    // Mid-frame reset.
    for (int v = 1; v <= 6; v++) send(DW'(v), waits);
    in_valid = 1'b0;
    rst      = 1'b1;
    p        = 0;
    q.delete();
    @(negedge clk);
    chk("midreset_outputs", {out_valid, out_col, out_window_last, out_frame_last}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int v = 101; v <= 116; v++) send(DW'(v), waits);
    drain();

    // Random data, input gaps and output backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 3 * W * H; i++) begin
      send(DW'($urandom), waits);
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
